rtc_pclk_to_clk1hz_tx: RTL and testbench
========================================

# rtc_pclk_to_clk1hz_tx

PCLK-domain transmitter that carries APB writes of the RTC Load and Match values across to the CLK1HZ counter domain. It uses a toggle request/acknowledge handshake and holds data stable until the far side acknowledges. A one-deep pending slot absorbs back-to-back writes. The block sits between the APB register decode and the CLK1HZ-side receiver; the PCLK-side status/count path runs in the opposite direction.

## Interface
- DATA_WIDTH, 32, width of transferred value
- SYNC_STAGES, 2, flops in ack synchroniser (min 2)
- PCLK  in  1  APB clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- WrLoad  in  1  one-cycle strobe: write PWDATA to Load
- WrMatch  in  1  one-cycle strobe: write PWDATA to Match
- PWDATA  in  DATA_WIDTH  write data, sampled with strobe
- XferAck  in  1  ack toggle from CLK1HZ domain (asynchronous)
- XferReq  out  1  request toggle to CLK1HZ domain
- XferData  out  DATA_WIDTH  value under transfer, stable while request outstanding
- XferSel  out  1  0 = Load, 1 = Match
- Busy  out  1  transfer outstanding or resync in progress
- Pending  out  1  pending slot occupied
- XferDone  out  1  one-cycle pulse per acknowledged transfer
- Overrun  out  1  one-cycle pulse when a pending write is overwritten or a write is discarded

## Operation
- Reset values: XferReq 0, XferData 0, XferSel 0, Busy 1, Pending 0, XferDone 0, Overrun 0. Ack synchroniser and AckSeen are cleared; state is RESYNC; the resync counter is 0.
- AckSeen <= synchronised ack every cycle in all states. AckEdge = sync_out ^ AckSeen.
- RESYNC: counts SYNC_STAGES+1 cycles, then moves to IDLE (or to WAIT_ACK if the pending slot is occupied, launching it). Ack edges here are absorbed silently. Writes go to the pending slot.
- IDLE: a strobe launches a transfer. At the next edge, XferData <= PWDATA, XferSel <= WrMatch, XferReq toggles, and the state moves to WAIT_ACK.
- WAIT_ACK: writes go to the pending slot (data, sel). On AckEdge:
  - XferDone pulses.
  - If the pending slot is occupied, its contents are launched (XferReq toggles again) and the slot frees.
  - Otherwise, a same-cycle strobe is launched directly.
  - Otherwise, the state goes to IDLE.
- Pending slot overwrite: a write while the slot is occupied and not freeing this cycle replaces the slot contents and pulses Overrun.
- Write and AckEdge in the same cycle with the slot occupied: the slot launches and the new write fills the slot. No Overrun.
- WrLoad and WrMatch asserted together: Load is taken, Match is discarded, and Overrun pulses.
- Busy = (state != IDLE). Pending reflects the slot valid bit.
- PRESET mid-transfer: the outstanding request is abandoned and the pending slot is dropped. The CLK1HZ receiver must reset its ack toggle from the same reset source. RESYNC masks any residual edge.

## Timing
- Strobe in cycle N → XferReq toggles and XferData is valid from cycle N+1.
- XferAck changes before edge E0 → AckEdge is true in the cycle after edge E(SYNC_STAGES-1). With the default of 2 stages, XferDone is high in the cycle after E2, i.e. 3 edges after the ack change.
- Chained launch from pending: XferReq toggles in the same cycle that XferDone is high.
- XferData/XferSel change only on a launch edge.
- Minimum request spacing: SYNC_STAGES+1 cycles plus the far-side turnaround.

## Structure
- Package rtc_xfer_pkg: state encoding (RESYNC, IDLE, WAIT_ACK), SEL_LOAD=1'b0, SEL_MATCH=1'b1, default DATA_WIDTH/SYNC_STAGES.
- Sub-module rtc_toggle_sync: SYNC_STAGES-deep synchronous-reset flop chain for XferAck. It is reused by the CLK1HZ receiver for XferReq.
- Top level: FSM, resync counter, launch register, pending slot, pulse generation.

## Test plan
- Reset release with XferAck=1 held → Busy=1 for 3 cycles, then 0. No XferDone, XferReq=0.
- WrLoad, PWDATA=0x0000_1234, cycle N → XferReq=1, XferSel=0, XferData=0x1234 at N+1. Toggling ack → XferDone 3 cycles later, Busy=0.
- WrLoad 0xA then WrMatch 0xB while waiting → Pending=1. The ack launches 0xB with XferSel=1 in the XferDone cycle, and XferReq toggles back to 0.
- Three writes 0x1, 0x2, 0x3 before any ack → 0x1 in flight, slot=0x3, one Overrun pulse. Only 0x1 and 0x3 are delivered.
- WrLoad and WrMatch together with 0x55 → Load transfer of 0x55, Overrun pulse.
- PRESET asserted in WAIT_ACK with the slot occupied → all outputs return to reset values, Pending=0, and no XferDone is generated for the abandoned transfer.

Source files
------------

// File: rtl/rtc_xfer_pkg.sv
// Shared types and defaults for the PCLK -> CLK1HZ toggle-handshake transfer path.
package rtc_xfer_pkg;

    typedef enum logic [1:0] {
        ST_RESYNC   = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } xfer_state_e;

    localparam logic SEL_LOAD  = 1'b0;
    localparam logic SEL_MATCH = 1'b1;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/rtc_toggle_sync.sv
// Flop-chain synchroniser for a level/toggle signal crossing into this clock domain.
// Shared by both ends of the Load/Match transfer path.
module rtc_toggle_sync
    import rtc_xfer_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the asynchronous input one stage deeper each cycle
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // synchroniser flops, cleared by the shared reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rtc_pclk_to_clk1hz_tx.sv
// PCLK-side transmitter carrying RTC Load/Match writes to the CLK1HZ domain
// over a toggle request/acknowledge handshake, with a one-deep pending slot.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RESYNC   | after reset: wait for the ack synchroniser to settle,
//               | swallowing any stale ack edge; writes land in the slot
//   ST_IDLE     | nothing outstanding; a write launches immediately
//   ST_WAIT_ACK | request outstanding, XferData held; writes land in the slot
module rtc_pclk_to_clk1hz_tx
    import rtc_xfer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  WrLoad,
    input  logic                  WrMatch,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  XferAck,
    output logic                  XferReq,
    output logic [DATA_WIDTH-1:0] XferData,
    output logic                  XferSel,
    output logic                  Busy,
    output logic                  Pending,
    output logic                  XferDone,
    output logic                  Overrun
);

    localparam int              CNT_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(SYNC_STAGES);

    xfer_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_seen_q, ack_seen_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  sel_q, sel_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  pend_sel_q, pend_sel_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;

    logic                  ack_sync;
    logic                  ack_edge;
    logic                  strobe;
    logic                  wr_sel;
    logic                  launch_slot;
    logic                  launch_wr;

    rtc_toggle_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk (PCLK),
        .rst (PRESET),
        .d   (XferAck),
        .q   (ack_sync)
    );

    assign ack_edge = ack_sync ^ ack_seen_q;
    assign strobe   = WrLoad | WrMatch;
    // Load wins when both strobes arrive together; the Match write is dropped
    assign wr_sel   = WrLoad ? SEL_LOAD : SEL_MATCH;

    // next-state, launch selection, pending-slot update and pulse generation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ack_seen_d   = ack_sync;
        req_d        = req_q;
        data_d       = data_q;
        sel_d        = sel_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_sel_d   = pend_sel_q;
        done_d       = 1'b0;
        ovr_d        = WrLoad & WrMatch;
        launch_slot  = 1'b0;
        launch_wr    = 1'b0;

        case (state_q)
            ST_RESYNC: begin
                if (cnt_q == CNT_TERM) begin
                    cnt_d = '0;
                    if (pend_valid_q) begin
                        launch_slot = 1'b1;
                        state_d     = ST_WAIT_ACK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                // a slot filled on the last resync cycle is drained from here
                if (pend_valid_q) begin
                    launch_slot = 1'b1;
                    state_d     = ST_WAIT_ACK;
                end else if (strobe) begin
                    launch_wr = 1'b1;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_edge) begin
                    done_d = 1'b1;
                    if (pend_valid_q) begin
                        launch_slot = 1'b1;
                    end else if (strobe) begin
                        launch_wr = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_RESYNC;
            end
        endcase

        if (launch_slot) begin
            req_d        = ~req_q;
            data_d       = pend_data_q;
            sel_d        = pend_sel_q;
            pend_valid_d = 1'b0;
        end

        if (launch_wr) begin
            req_d  = ~req_q;
            data_d = PWDATA;
            sel_d  = wr_sel;
        end

        // writes not launched directly go to the slot; overwriting live contents is an overrun
        if (strobe && !launch_wr) begin
            if (pend_valid_q && !launch_slot) begin
                ovr_d = 1'b1;
            end
            pend_valid_d = 1'b1;
            pend_data_d  = PWDATA;
            pend_sel_d   = wr_sel;
        end
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_RESYNC;
            cnt_q        <= '0;
            ack_seen_q   <= 1'b0;
            req_q        <= 1'b0;
            data_q       <= '0;
            sel_q        <= SEL_LOAD;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_sel_q   <= SEL_LOAD;
            done_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ack_seen_q   <= ack_seen_d;
            req_q        <= req_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_sel_q   <= pend_sel_d;
            done_q       <= done_d;
            ovr_q        <= ovr_d;
        end
    end

    assign XferReq  = req_q;
    assign XferData = data_q;
    assign XferSel  = sel_q;
    assign Busy     = (state_q != ST_IDLE);
    assign Pending  = pend_valid_q;
    assign XferDone = done_q;
    assign Overrun  = ovr_q;

endmodule

// File: tb/tb_rtc_pclk_to_clk1hz_tx.sv
// Bench for rtc_pclk_to_clk1hz_tx: directed scenarios followed by random writes
// and a random-latency far-side acknowledger, checked against a transaction model.
module tb_rtc_pclk_to_clk1hz_tx;

    localparam int DW          = 32;
    localparam int SYNC_STAGES = 2;

    logic          PCLK;
    logic          PRESET;
    logic          WrLoad;
    logic          WrMatch;
    logic [DW-1:0] PWDATA;
    logic          XferAck;
    logic          XferReq;
    logic [DW-1:0] XferData;
    logic          XferSel;
    logic          Busy;
    logic          Pending;
    logic          XferDone;
    logic          Overrun;

    int checks   = 0;
    int failures = 0;

    // transaction model: one transfer in flight plus an optional waiting write
    logic          m_inflight;
    logic          m_slot_v;
    logic [DW-1:0] m_slot_d;
    logic          m_slot_s;
    logic          m_req;
    logic [DW-1:0] m_data;
    logic          m_sel;
    logic          m_done;
    logic          m_ovr;
    logic [7:0]    tog_hist;

    logic          rx_last;
    int            ack_cnt;
    int            r;
    logic          tog;
    logic          rwl;
    logic          rwm;

    rtc_pclk_to_clk1hz_tx #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .WrLoad   (WrLoad),
        .WrMatch  (WrMatch),
        .PWDATA   (PWDATA),
        .XferAck  (XferAck),
        .XferReq  (XferReq),
        .XferData (XferData),
        .XferSel  (XferSel),
        .Busy     (Busy),
        .Pending  (Pending),
        .XferDone (XferDone),
        .Overrun  (Overrun)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("req",  {31'd0, XferReq},  {31'd0, m_req});
        chk("data", XferData,          m_data);
        chk("sel",  {31'd0, XferSel},  {31'd0, m_sel});
        chk("busy", {31'd0, Busy},     {31'd0, m_inflight});
        chk("pend", {31'd0, Pending},  {31'd0, m_slot_v});
        chk("done", {31'd0, XferDone}, {31'd0, m_done});
        chk("ovr",  {31'd0, Overrun},  {31'd0, m_ovr});
    endtask

    task automatic send(input logic [DW-1:0] d, input logic s);
        m_req  = ~m_req;
        m_data = d;
        m_sel  = s;
    endtask

    // one PCLK cycle: drive inputs, advance the model, then compare after the edge
    task automatic step(input logic wl, input logic wm, input logic [DW-1:0] wd, input logic tg);
        logic wr;
        logic wsel;
        logic eff;
        WrLoad  = wl;
        WrMatch = wm;
        PWDATA  = wd;
        if (tg) XferAck = ~XferAck;
        tog_hist = {tog_hist[6:0], tg};
        // an ack toggle is acted on SYNC_STAGES cycles after it is driven
        eff  = tog_hist[SYNC_STAGES];
        wr   = wl | wm;
        wsel = wl ? 1'b0 : 1'b1;
        m_done = 1'b0;
        m_ovr  = wl & wm;
        if (eff) begin
            m_done = 1'b1;
            if (m_slot_v) begin
                send(m_slot_d, m_slot_s);
                m_slot_v = 1'b0;
                if (wr) begin
                    m_slot_v = 1'b1;
                    m_slot_d = wd;
                    m_slot_s = wsel;
                end
            end else if (wr) begin
                send(wd, wsel);
            end else begin
                m_inflight = 1'b0;
            end
        end else if (!m_inflight) begin
            if (wr) begin
                send(wd, wsel);
                m_inflight = 1'b1;
            end
        end else if (wr) begin
            if (m_slot_v) m_ovr = 1'b1;
            m_slot_v = 1'b1;
            m_slot_d = wd;
            m_slot_s = wsel;
        end
        @(posedge PCLK);
        #1;
        WrLoad  = 1'b0;
        WrMatch = 1'b0;
        check_all();
    endtask

    task automatic ack_and_wait();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset(input logic ack_lvl);
        PRESET  = 1'b1;
        WrLoad  = 1'b0;
        WrMatch = 1'b0;
        XferAck = ack_lvl;
        @(posedge PCLK);
        #1;
        @(posedge PCLK);
        #1;
        chk("rst_req",  {31'd0, XferReq},  32'd0);
        chk("rst_data", XferData,          32'd0);
        chk("rst_sel",  {31'd0, XferSel},  32'd0);
        chk("rst_busy", {31'd0, Busy},     32'd1);
        chk("rst_pend", {31'd0, Pending},  32'd0);
        chk("rst_done", {31'd0, XferDone}, 32'd0);
        chk("rst_ovr",  {31'd0, Overrun},  32'd0);
        PRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("resync_busy", {31'd0, Busy},     {31'd0, (i < 3)});
            chk("resync_done", {31'd0, XferDone}, 32'd0);
            chk("resync_req",  {31'd0, XferReq},  32'd0);
            if (i < 3) begin
                @(posedge PCLK);
                #1;
            end
        end
        m_inflight = 1'b0;
        m_slot_v   = 1'b0;
        m_slot_d   = '0;
        m_slot_s   = 1'b0;
        m_req      = 1'b0;
        m_data     = '0;
        m_sel      = 1'b0;
        m_done     = 1'b0;
        m_ovr      = 1'b0;
        tog_hist   = '0;
    endtask

    initial begin
        PRESET   = 1'b1;
        WrLoad   = 1'b0;
        WrMatch  = 1'b0;
        PWDATA   = '0;
        XferAck  = 1'b0;
        tog_hist = '0;

        // reset release with the far-side ack already high
        do_reset(1'b1);

        // single Load transfer
        step(1'b1, 1'b0, 32'h0000_1234, 1'b0);
        chk("t2_req",  {31'd0, XferReq}, 32'd1);
        chk("t2_sel",  {31'd0, XferSel}, 32'd0);
        chk("t2_data", XferData,         32'h0000_1234);
        ack_and_wait();
        chk("t2_done", {31'd0, XferDone}, 32'd1);
        chk("t2_busy", {31'd0, Busy},     32'd0);

        // Load then Match while waiting: Match chained from the slot
        step(1'b1, 1'b0, 32'hA, 1'b0);
        step(1'b0, 1'b1, 32'hB, 1'b0);
        chk("t3_pend", {31'd0, Pending}, 32'd1);
        ack_and_wait();
        chk("t3_done", {31'd0, XferDone}, 32'd1);
        chk("t3_data", XferData,          32'hB);
        chk("t3_sel",  {31'd0, XferSel},  32'd1);
        chk("t3_req",  {31'd0, XferReq},  32'd1);
        ack_and_wait();

        // three writes before any ack: middle one lost
        step(1'b1, 1'b0, 32'h1, 1'b0);
        step(1'b1, 1'b0, 32'h2, 1'b0);
        step(1'b1, 1'b0, 32'h3, 1'b0);
        chk("t4_ovr",  {31'd0, Overrun}, 32'd1);
        chk("t4_data", XferData,         32'h1);
        ack_and_wait();
        chk("t4_data2", XferData, 32'h3);
        ack_and_wait();
        chk("t4_busy", {31'd0, Busy}, 32'd0);

        // simultaneous Load and Match strobes
        step(1'b1, 1'b1, 32'h55, 1'b0);
        chk("t5_data", XferData,         32'h55);
        chk("t5_sel",  {31'd0, XferSel}, 32'd0);
        chk("t5_ovr",  {31'd0, Overrun}, 32'd1);
        ack_and_wait();

        // reset while waiting with the slot occupied
        step(1'b1, 1'b0, 32'h77, 1'b0);
        step(1'b0, 1'b1, 32'h88, 1'b0);
        chk("t6_pend", {31'd0, Pending}, 32'd1);
        do_reset(1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);

        // random writes with a random-latency far-side acknowledger, then drain
        rx_last = XferReq;
        ack_cnt = -1;
        for (int i = 0; i < 460; i++) begin
            if (i >= 400 && !m_inflight && !m_slot_v) break;
            tog = 1'b0;
            if (XferReq !== rx_last) begin
                rx_last = XferReq;
                ack_cnt = $urandom_range(0, 3);
            end
            if (ack_cnt == 0) tog = 1'b1;
            if (ack_cnt >= 0) ack_cnt--;
            rwl = 1'b0;
            rwm = 1'b0;
            if (i < 400) begin
                r = $urandom_range(0, 9);
                rwl = (r <= 2) || (r == 5);
                rwm = (r == 3) || (r == 4) || (r == 5);
            end
            step(rwl, rwm, $urandom(), tog);
        end
        chk("drain_busy", {31'd0, Busy},    32'd0);
        chk("drain_pend", {31'd0, Pending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
